wb_burst_initiator: RTL and testbench
=====================================

// Module: wb_burst_initiator
// PURPOSE
// Wishbone B4 pipelined-mode initiator for the MCU's SPI bridge. Takes a burst command (address,
// beat count, direction) on a valid/ready interface. Issues one single-outstanding Wishbone
// transfer per beat to peripherals such as the RAM port, with auto-incrementing address.
// Write data streams in and read data streams out. A per-beat timeout aborts stuck transfers.
// PARAMETERS
// TIMEOUT_CYCLES  64  cycles from strobe assertion without ack before the burst aborts (>=2)
// PORTS
// wb_clock_i     in   1              system clock; everything is rising-edge
// wb_reset_i     in   1              synchronous, active-high reset
// cmd_valid_i    in   1              command present
// cmd_ready_o    out  1              initiator idle; command accepted when valid&&ready
// cmd_we_i       in   1              0 = read burst, 1 = write burst
// cmd_addr_i     in   WB_ADDR_WIDTH  first beat address
// cmd_len_i      in   WB_LEN_WIDTH   beats minus one (0 -> 1 beat, 255 -> 256 beats)
// wr_data_i      in   DATA_WIDTH     write beat data
// wr_valid_i     in   1              write data present
// wr_ready_o     out  1              initiator wants write data; taken when valid&&ready
// rd_data_o      out  DATA_WIDTH     read beat data, valid while rd_valid_o
// rd_valid_o     out  1              one-cycle pulse per read beat; consumer cannot stall
// done_o         out  1              one-cycle pulse at burst end (normal or aborted)
// err_o          out  1              one-cycle pulse with done_o when the burst timed out
// wbc_addr_o     out  WB_ADDR_WIDTH  Wishbone address
// wbc_data_o     out  DATA_WIDTH     Wishbone write data
// wbc_data_i     in   DATA_WIDTH     Wishbone read data, sampled on ack
// wbc_we_o       out  1              Wishbone direction
// wbc_cycle_o    out  1              Wishbone CYC
// wbc_strobe_o   out  1              Wishbone STB
// wbc_stall_i    in   1              peripheral stall
// wbc_ack_i      in   1              peripheral ack
// BEHAVIOUR
// - Reset: state IDLE. cmd_ready_o=0 in the reset cycle, then 1 from the first post-reset cycle.
//   All other outputs 0 (addr/data 0). Reset mid-burst drops CYC/STB at the next edge and
//   discards the burst with no done_o.
// - All outputs registered. One-hot states: IDLE, WDATA, REQ, WAIT_ACK.
// - IDLE: on valid&&ready, latch we, addr, beats=len. Drop cmd_ready_o.
//   Go to WDATA if write, else to REQ with cycle_o=strobe_o=1.
// - WDATA: wr_ready_o=1. On wr_valid_i, latch wbc_data_o, drop wr_ready_o, raise CYC/STB, go REQ.
//   CYC holds across the whole burst, including WDATA gaps after the first beat.
// - REQ: STB held until a cycle with STB && !wbc_stall_i, which is the acceptance edge.
//   Then drop STB and go to WAIT_ACK. If ack arrives on the acceptance cycle, treat it as WAIT_ACK's ack.
// - WAIT_ACK: on ack, a read registers wbc_data_i into rd_data_o with rd_valid_o=1 next cycle.
//   If beats==0: drop CYC, pulse done_o, return to IDLE (cmd_ready_o=1 next cycle).
//   Else: beats-1, addr+1 mod 2^WB_ADDR_WIDTH (wraps silently), then write -> WDATA,
//   read -> REQ with STB=1.
// - Ack outside REQ/WAIT_ACK is ignored. Only one transfer is ever outstanding.
// - Timeout: counter clears on STB rise and counts in REQ and WAIT_ACK.
//   At TIMEOUT_CYCLES with no ack: drop CYC/STB, pulse done_o+err_o, abandon remaining beats, IDLE.
//   Ack on the same cycle as expiry wins: the beat completes normally.
// - WDATA has no timeout; the bridge must supply data.
// - Write beats follow in command order; cmd_len_i=N needs exactly N+1 wr handshakes.
// STRUCTURE
// - common_pkg: add localparam WB_LEN_WIDTH=8. Reuse WB_ADDR_WIDTH and DATA_WIDTH. State encoding stays local.
// - Single flat module; the FSM, beat/address counters and timeout counter are small. No sub-module.
// TESTING
// Bench responder: ram-like, stall registered one cycle after accept, ack 5 cycles after accept.
// 1 Read len=0 addr=0x01234, mem[0x01234]=0xA5 -> one STB accept, rd_valid_o with 0xA5, done_o, err_o=0, CYC low after.
// 2 Write len=3 addr=0x00010, data 11,22,33,44 -> mem[0x10..0x13]=11,22,33,44; four acks; CYC continuous; one done_o.
// 3 Read len=1 addr=all-ones -> beat addresses all-ones then 0x00000; two rd_valid_o pulses.
// 4 Responder never acks, TIMEOUT_CYCLES=64 -> CYC/STB drop, done_o+err_o together 64 cycles after STB rise; next command works.
// 5 Stall held 10 cycles at first beat -> STB held 10 cycles, accepted on first !stall; ack on timeout expiry cycle -> no err_o.
// 6 wb_reset_i pulsed mid write burst (beat 2 of 4) -> CYC/STB 0 next edge, no done_o; cmd_ready_o=1 after.

Source files
------------

// File: rtl/common_pkg.sv
// Shared widths for the MCU SPI bridge Wishbone fabric.
package common_pkg;

  localparam int WB_ADDR_WIDTH = 20;
  localparam int DATA_WIDTH    = 32;
  localparam int WB_LEN_WIDTH  = 8;

endpackage

// File: rtl/wb_burst_initiator.sv
// Wishbone B4 pipelined burst initiator: one transfer outstanding at a time,
// auto-incrementing address, streamed write/read data, per-beat timeout abort.
module wb_burst_initiator
  import common_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     wb_clock_i,
  input  logic                     wb_reset_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_we_i,
  input  logic [WB_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [WB_LEN_WIDTH-1:0]  cmd_len_i,
  input  logic [DATA_WIDTH-1:0]    wr_data_i,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  output logic [DATA_WIDTH-1:0]    rd_data_o,
  output logic                     rd_valid_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [WB_ADDR_WIDTH-1:0] wbc_addr_o,
  output logic [DATA_WIDTH-1:0]    wbc_data_o,
  input  logic [DATA_WIDTH-1:0]    wbc_data_i,
  output logic                     wbc_we_o,
  output logic                     wbc_cycle_o,
  output logic                     wbc_strobe_o,
  input  logic                     wbc_stall_i,
  input  logic                     wbc_ack_i
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_WDATA    = 4'b0010,
    ST_REQ      = 4'b0100,
    ST_WAIT_ACK = 4'b1000
  } state_t;

  // Counter only needs to reach TIMEOUT_CYCLES-1; expiry is detected on that value.
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t                  state;
  logic [WB_LEN_WIDTH-1:0] beats;
  logic [TW-1:0]           tmo_cnt;
  logic                    accept_now;
  logic                    ack_now;

  // An ack during REQ only counts when it lands on the acceptance cycle itself.
  assign accept_now = (state == ST_REQ) && !wbc_stall_i;
  assign ack_now    = wbc_ack_i && ((state == ST_WAIT_ACK) || accept_now);

  // Burst sequencer: command latch, beat/address stepping, timeout and pulses.
  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) begin
      state        <= ST_IDLE;
      cmd_ready_o  <= 1'b0;
      wr_ready_o   <= 1'b0;
      rd_data_o    <= '0;
      rd_valid_o   <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      wbc_addr_o   <= '0;
      wbc_data_o   <= '0;
      wbc_we_o     <= 1'b0;
      wbc_cycle_o  <= 1'b0;
      wbc_strobe_o <= 1'b0;
      beats        <= '0;
      tmo_cnt      <= '0;
    end else begin
      rd_valid_o <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      case (state)
        ST_IDLE: begin
          cmd_ready_o <= 1'b1;
          if (cmd_valid_i && cmd_ready_o) begin
            cmd_ready_o <= 1'b0;
            wbc_we_o    <= cmd_we_i;
            wbc_addr_o  <= cmd_addr_i;
            beats       <= cmd_len_i;
            if (cmd_we_i) begin
              wr_ready_o <= 1'b1;
              state      <= ST_WDATA;
            end else begin
              wbc_cycle_o  <= 1'b1;
              wbc_strobe_o <= 1'b1;
              tmo_cnt      <= '0;
              state        <= ST_REQ;
            end
          end
        end
        ST_WDATA: begin
          if (wr_valid_i && wr_ready_o) begin
            wbc_data_o   <= wr_data_i;
            wr_ready_o   <= 1'b0;
            wbc_cycle_o  <= 1'b1;
            wbc_strobe_o <= 1'b1;
            tmo_cnt      <= '0;
            state        <= ST_REQ;
          end
        end
        ST_REQ, ST_WAIT_ACK: begin
          if (accept_now) begin
            wbc_strobe_o <= 1'b0;
          end
          if (ack_now) begin
            if (!wbc_we_o) begin
              rd_data_o  <= wbc_data_i;
              rd_valid_o <= 1'b1;
            end
            if (beats == '0) begin
              wbc_cycle_o  <= 1'b0;
              wbc_strobe_o <= 1'b0;
              done_o       <= 1'b1;
              cmd_ready_o  <= 1'b1;
              state        <= ST_IDLE;
            end else begin
              beats      <= beats - WB_LEN_WIDTH'(1);
              wbc_addr_o <= wbc_addr_o + WB_ADDR_WIDTH'(1);
              if (wbc_we_o) begin
                wbc_strobe_o <= 1'b0;
                wr_ready_o   <= 1'b1;
                state        <= ST_WDATA;
              end else begin
                wbc_strobe_o <= 1'b1;
                tmo_cnt      <= '0;
                state        <= ST_REQ;
              end
            end
          end else if (tmo_cnt == TMO_LAST) begin
            wbc_cycle_o  <= 1'b0;
            wbc_strobe_o <= 1'b0;
            done_o       <= 1'b1;
            err_o        <= 1'b1;
            cmd_ready_o  <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (accept_now) begin
              state <= ST_WAIT_ACK;
            end
          end
        end
        default: begin
          wbc_cycle_o  <= 1'b0;
          wbc_strobe_o <= 1'b0;
          wr_ready_o   <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_initiator.sv
// Self-checking bench for wb_burst_initiator with a RAM-like Wishbone responder
// and a transaction-level expectation model.
module tb_wb_burst_initiator;
  import common_pkg::*;

  logic                     clk;
  logic                     reset;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_we;
  logic [WB_ADDR_WIDTH-1:0] cmd_addr;
  logic [WB_LEN_WIDTH-1:0]  cmd_len;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     wr_valid;
  logic                     wr_ready;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     rd_valid;
  logic                     done;
  logic                     err;
  logic [WB_ADDR_WIDTH-1:0] wbc_addr;
  logic [DATA_WIDTH-1:0]    wbc_wdata;
  logic [DATA_WIDTH-1:0]    wbc_rdata;
  logic                     wbc_we;
  logic                     wbc_cyc;
  logic                     wbc_stb;
  logic                     wbc_stall;
  logic                     wbc_ack;

  wb_burst_initiator #(.TIMEOUT_CYCLES(64)) dut (
    .wb_clock_i  (clk),
    .wb_reset_i  (reset),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_addr_i  (cmd_addr),
    .cmd_len_i   (cmd_len),
    .wr_data_i   (wr_data),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .done_o      (done),
    .err_o       (err),
    .wbc_addr_o  (wbc_addr),
    .wbc_data_o  (wbc_wdata),
    .wbc_data_i  (wbc_rdata),
    .wbc_we_o    (wbc_we),
    .wbc_cycle_o (wbc_cyc),
    .wbc_strobe_o(wbc_stb),
    .wbc_stall_i (wbc_stall),
    .wbc_ack_i   (wbc_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic                     we;
    logic [DATA_WIDTH-1:0]    data;
  } beat_t;

  int checks = 0;
  int errors = 0;

  beat_t                 exp_beats[$];
  logic [DATA_WIDTH-1:0] exp_rd[$];
  bit                    exp_done[$];
  logic [DATA_WIDTH-1:0] wr_q[$];
  logic [DATA_WIDTH-1:0] wdata[$];
  logic [DATA_WIDTH-1:0] model_mem [logic [WB_ADDR_WIDTH-1:0]];
  logic [DATA_WIDTH-1:0] mem [logic [WB_ADDR_WIDTH-1:0]];

  int bp = 0;
  int rp = 0;
  int dp = 0;

  int no_ack    = 0;
  int ack_delay = 5;
  int stall_cfg = 0;

  int st_done_idx, st_acc, st_stall, st_rd, st_cyc_low;
  logic st_err, st_cyc, st_stb, st_ready;
  logic [DATA_WIDTH-1:0] st_rdata;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: derive the expected Wishbone beats, read data and completion for a burst.
  task automatic expect_burst(input bit we, input logic [WB_ADDR_WIDTH-1:0] addr, input int len,
                              input int naccept, input bit aborted);
    beat_t b;
    logic [WB_ADDR_WIDTH-1:0] a;
    for (int i = 0; i <= len; i++) begin
      a = addr + WB_ADDR_WIDTH'(i);
      if (we) begin
        wr_q.push_back(wdata[i]);
        model_mem[a] = wdata[i];
      end
      if (i < naccept) begin
        b.addr = a;
        b.we   = we;
        b.data = we ? wdata[i] : '0;
        exp_beats.push_back(b);
      end
      if (!we && !aborted) exp_rd.push_back(model_mem.exists(a) ? model_mem[a] : '0);
    end
    exp_done.push_back(aborted);
  endtask

  task automatic applyStimulus(input bit we, input logic [WB_ADDR_WIDTH-1:0] addr,
                               input logic [WB_LEN_WIDTH-1:0] len);
    int n = 0;
    @(posedge clk); #1;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("cmd_ready_wait", 32'(cmd_ready === 1'b1), 32'd1);
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit seen_cyc = 0;
    st_done_idx = -1; st_acc = 0; st_stall = 0; st_rd = 0; st_cyc_low = 0;
    st_err = 0; st_cyc = 0; st_stb = 0; st_ready = 0; st_rdata = '0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (wbc_stb === 1'b1) begin
        if (wbc_stall === 1'b1) st_stall++;
        else st_acc++;
      end
      if (rd_valid === 1'b1) st_rd++;
      if (done === 1'b1) begin
        st_done_idx = i;
        st_err = err; st_cyc = wbc_cyc; st_stb = wbc_stb;
        st_ready = cmd_ready; st_rdata = rd_data;
        break;
      end
      if (wbc_cyc === 1'b1) seen_cyc = 1;
      else if (seen_cyc) st_cyc_low++;
    end
    checkOutput("done_within_bound", 32'(st_done_idx >= 0), 32'd1);
  endtask

  // Write data source: streams queued beats, dropping whatever remains on reset.
  int wptr = 0;
  bit take = 0;
  initial begin
    wr_valid = 1'b0;
    wr_data  = '0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        wptr = wr_q.size();
        take = 0;
      end else begin
        take = wr_valid && (wr_ready === 1'b1);
      end
      @(posedge clk); #1;
      if (take) wptr++;
      wr_valid = (wptr < wr_q.size());
      wr_data  = wr_valid ? wr_q[wptr] : '0;
    end
  end

  // RAM-like responder: programmable first-beat stall, ack latency, or silence.
  initial begin
    bit acc_s, cyc_s, stb_s, pending, post_acc, lwe;
    int cnt, stall_left;
    logic [WB_ADDR_WIDTH-1:0] la;
    logic [DATA_WIDTH-1:0] ld;
    pending = 0; post_acc = 0; cnt = 0; stall_left = 0; lwe = 0; la = '0; ld = '0;
    mem[20'h01234] = 32'h0000_00A5;
    mem[20'hFFFFF] = 32'hDEAD_BEEF;
    mem[20'h00000] = 32'h1234_5678;
    wbc_ack = 1'b0; wbc_stall = 1'b0; wbc_rdata = '0;
    forever begin
      @(negedge clk);
      acc_s = (wbc_stb === 1'b1) && (wbc_stall == 1'b0);
      cyc_s = (wbc_cyc === 1'b1);
      stb_s = (wbc_stb === 1'b1);
      if (acc_s) begin
        la = wbc_addr; lwe = wbc_we; ld = wbc_wdata;
      end
      @(posedge clk); #1;
      wbc_ack = 1'b0;
      if (!cyc_s) pending = 0;
      if (acc_s) begin
        pending = 1;
        cnt = ack_delay;
      end
      if (pending && no_ack == 0) begin
        cnt--;
        if (cnt == 0) begin
          wbc_ack = 1'b1;
          pending = 0;
          if (lwe) mem[la] = ld;
          else wbc_rdata = mem.exists(la) ? mem[la] : '0;
        end
      end
      if (!cyc_s) stall_left = stall_cfg;
      else if (stb_s && stall_left != 0) stall_left--;
      post_acc  = acc_s;
      wbc_stall = (stall_left != 0) || post_acc;
    end
  end

  // Compare process: every accepted beat, read pulse and completion against the model.
  initial begin
    int outstanding = 0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        bp = exp_beats.size();
        rp = exp_rd.size();
        dp = exp_done.size();
        outstanding = 0;
      end else begin
        if (wbc_stb === 1'b1 && wbc_cyc !== 1'b1) checkOutput("stb_without_cyc", 32'd1, 32'd0);
        if (wbc_stb === 1'b1 && wbc_stall === 1'b0) begin
          checkOutput("single_outstanding", 32'(outstanding), 32'd0);
          outstanding = 1;
          if (bp < exp_beats.size()) begin
            checkOutput("beat_addr", 32'(wbc_addr), 32'(exp_beats[bp].addr));
            checkOutput("beat_we", 32'(wbc_we), 32'(exp_beats[bp].we));
            if (exp_beats[bp].we) checkOutput("beat_wdata", wbc_wdata, exp_beats[bp].data);
            bp++;
          end else begin
            checkOutput("unexpected_beat", 32'd1, 32'd0);
          end
        end
        if (wbc_ack === 1'b1 && outstanding > 0 && wbc_stb !== 1'b1) outstanding = 0;
        if (rd_valid === 1'b1) begin
          if (rp < exp_rd.size()) begin
            checkOutput("rd_data", rd_data, exp_rd[rp]);
            rp++;
          end else begin
            checkOutput("unexpected_rd_valid", 32'd1, 32'd0);
          end
        end
        if (err === 1'b1 && done !== 1'b1) checkOutput("err_without_done", 32'd1, 32'd0);
        if (done === 1'b1) begin
          outstanding = 0;
          if (dp < exp_done.size()) begin
            checkOutput("done_err", 32'(err), 32'(exp_done[dp]));
            dp++;
          end else begin
            checkOutput("unexpected_done", 32'd1, 32'd0);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int dseen;
    reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    model_mem[20'h01234] = 32'h0000_00A5;
    model_mem[20'hFFFFF] = 32'hDEAD_BEEF;
    model_mem[20'h00000] = 32'h1234_5678;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("reset_cyc", 32'(wbc_cyc), 32'd0);
    checkOutput("reset_stb", 32'(wbc_stb), 32'd0);
    checkOutput("reset_addr", 32'(wbc_addr), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_wr_ready", 32'(wr_ready), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);

    // 1: single-beat read
    $display("[TB] read len=0");
    expect_burst(1'b0, 20'h01234, 0, 1, 1'b0);
    applyStimulus(1'b0, 20'h01234, 8'd0);
    wait_done(200);
    checkOutput("t1_done_cycle", 32'(st_done_idx), 32'd6);
    checkOutput("t1_accepts", 32'(st_acc), 32'd1);
    checkOutput("t1_rdata", st_rdata, 32'h0000_00A5);
    checkOutput("t1_err", 32'(st_err), 32'd0);
    checkOutput("t1_cyc_after", 32'(st_cyc), 32'd0);
    checkOutput("t1_ready_after", 32'(st_ready), 32'd1);

    // 2: four-beat write
    $display("[TB] write len=3");
    wdata = '{32'h11, 32'h22, 32'h33, 32'h44};
    expect_burst(1'b1, 20'h00010, 3, 4, 1'b0);
    applyStimulus(1'b1, 20'h00010, 8'd3);
    wait_done(300);
    checkOutput("t2_done_cycle", 32'(st_done_idx), 32'd28);
    checkOutput("t2_accepts", 32'(st_acc), 32'd4);
    checkOutput("t2_cyc_gaps", 32'(st_cyc_low), 32'd0);
    checkOutput("t2_mem10", mem.exists(20'h10) ? mem[20'h10] : 32'hX, 32'h11);
    checkOutput("t2_mem11", mem.exists(20'h11) ? mem[20'h11] : 32'hX, 32'h22);
    checkOutput("t2_mem12", mem.exists(20'h12) ? mem[20'h12] : 32'hX, 32'h33);
    checkOutput("t2_mem13", mem.exists(20'h13) ? mem[20'h13] : 32'hX, 32'h44);

    // Read the written block back
    expect_burst(1'b0, 20'h00010, 3, 4, 1'b0);
    applyStimulus(1'b0, 20'h00010, 8'd3);
    wait_done(300);
    checkOutput("rb_rd_pulses", 32'(st_rd), 32'd4);
    checkOutput("rb_last_data", st_rdata, 32'h44);

    // 3: address wrap
    $display("[TB] read wrap");
    expect_burst(1'b0, 20'hFFFFF, 1, 2, 1'b0);
    applyStimulus(1'b0, 20'hFFFFF, 8'd1);
    wait_done(200);
    checkOutput("t3_rd_pulses", 32'(st_rd), 32'd2);
    checkOutput("t3_last_data", st_rdata, 32'h1234_5678);

    // 4: responder never acks
    $display("[TB] timeout");
    no_ack = 1;
    expect_burst(1'b0, 20'h00100, 2, 1, 1'b1);
    applyStimulus(1'b0, 20'h00100, 8'd2);
    wait_done(200);
    checkOutput("t4_done_cycle", 32'(st_done_idx), 32'd64);
    checkOutput("t4_err", 32'(st_err), 32'd1);
    checkOutput("t4_cyc", 32'(st_cyc), 32'd0);
    checkOutput("t4_stb", 32'(st_stb), 32'd0);
    checkOutput("t4_rd_pulses", 32'(st_rd), 32'd0);
    no_ack = 0;
    expect_burst(1'b0, 20'h01234, 0, 1, 1'b0);
    applyStimulus(1'b0, 20'h01234, 8'd0);
    wait_done(200);
    checkOutput("t4_next_rdata", st_rdata, 32'h0000_00A5);
    checkOutput("t4_next_err", 32'(st_err), 32'd0);

    // 5: stall then ack on the expiry cycle, and one cycle past it
    $display("[TB] stall and expiry boundary");
    stall_cfg = 10;
    ack_delay = 53;
    expect_burst(1'b0, 20'h01234, 0, 1, 1'b0);
    applyStimulus(1'b0, 20'h01234, 8'd0);
    wait_done(200);
    checkOutput("t5_stall_cycles", 32'(st_stall), 32'd10);
    checkOutput("t5_accepts", 32'(st_acc), 32'd1);
    checkOutput("t5_done_cycle", 32'(st_done_idx), 32'd64);
    checkOutput("t5_err", 32'(st_err), 32'd0);
    checkOutput("t5_rdata", st_rdata, 32'h0000_00A5);
    ack_delay = 54;
    expect_burst(1'b0, 20'h01234, 0, 1, 1'b1);
    applyStimulus(1'b0, 20'h01234, 8'd0);
    wait_done(200);
    checkOutput("t5b_done_cycle", 32'(st_done_idx), 32'd64);
    checkOutput("t5b_err", 32'(st_err), 32'd1);
    stall_cfg = 0;
    ack_delay = 5;

    // 6: reset during beat 2 of a 4-beat write
    $display("[TB] reset mid burst");
    wdata = '{32'h55, 32'h66, 32'h77, 32'h88};
    expect_burst(1'b1, 20'h00020, 3, 4, 1'b0);
    applyStimulus(1'b1, 20'h00020, 8'd3);
    n = 0;
    for (int i = 0; i < 200 && n < 2; i++) begin
      @(negedge clk);
      if (wbc_stb === 1'b1 && wbc_stall === 1'b0) n++;
    end
    checkOutput("t6_second_beat", 32'(n), 32'd2);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("t6_cyc", 32'(wbc_cyc), 32'd0);
    checkOutput("t6_stb", 32'(wbc_stb), 32'd0);
    checkOutput("t6_ready_in_reset", 32'(cmd_ready), 32'd0);
    dseen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) dseen++;
    end
    checkOutput("t6_no_done", 32'(dseen), 32'd0);
    checkOutput("t6_ready_after", 32'(cmd_ready), 32'd1);
    expect_burst(1'b0, 20'hFFFFF, 0, 1, 1'b0);
    applyStimulus(1'b0, 20'hFFFFF, 8'd0);
    wait_done(200);
    checkOutput("t6_next_rdata", st_rdata, 32'hDEAD_BEEF);

    repeat (4) @(negedge clk);
    checkOutput("all_beats_seen", 32'(bp), 32'(exp_beats.size()));
    checkOutput("all_reads_seen", 32'(rp), 32'(exp_rd.size()));
    checkOutput("all_dones_seen", 32'(dp), 32'(exp_done.size()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
